activation_sequencer: RTL
=========================

// Module: activation_sequencer
// PURPOSE
// Time-multiplexes one step-activation unit (unsigned strict compare sum > threshold -> 4'b1111 else 4'b0000) across all neurons of a layer.
// Accepts a layer's accumulated neuron sums as a stream in neuron-index order and looks up a per-neuron threshold from a local register file.
// Returns each activation with its index on a valid/ready output stream. Sits between the MAC/accumulator stage and the next layer's input buffer.
// PARAMETERS
// N_NEURONS  4  neurons per layer; index wraps after N_NEURONS-1
// W          4  width of sums, thresholds and activations
// IDX_W      2  index width, must satisfy 2**IDX_W >= N_NEURONS
// PORTS
// clk        in   1      single clock, rising edge
// rst        in   1      asynchronous, active-high reset
// cfg_we     in   1      threshold write strobe
// cfg_addr   in   IDX_W  threshold index to write
// cfg_thr    in   W      threshold value
// in_valid   in   1      in_data holds a neuron sum
// in_ready   out  1      block accepts in_data this cycle
// in_data    in   W      neuron sum, unsigned
// out_valid  out  1      out_data/out_idx/out_last valid
// out_ready  in   1      downstream accepts result
// out_data   out  W      activation: all ones or all zeros
// out_idx    out  IDX_W  neuron index of out_data
// out_last   out  1      result is for neuron N_NEURONS-1
// busy       out  1      layer in progress (state != IDLE)
// layer_done out  1      one-cycle pulse after last result handshake
// BEHAVIOUR
// Interface: one clock; reset is asynchronous and active-high.
// Reset values: out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, layer_done=0, idx counter=0, all thresholds=0, state=IDLE.
// - in_ready = !out_valid || out_ready (single output register, no skid buffer).
// - Input accept (in_valid && in_ready): out_data <= (in_data > thr[idx]) ? {W{1'b1}} : 0; out_idx <= idx; out_last <= (idx==N_NEURONS-1); out_valid <= 1.
// - Latency: result is visible the cycle after accept. Full throughput: one result per cycle when out_ready stays high.
// - Output handshake without a new accept clears out_valid. Handshake plus accept in the same cycle keeps out_valid=1 with the new data.
// - out_data/out_idx/out_last hold stable while out_valid && !out_ready.
// - idx increments on every accept. It wraps to 0 after the accept at N_NEURONS-1 and never exceeds N_NEURONS-1.
// - Compare is unsigned and strict: equal yields zeros. Full-range values need no extension.
// FSM:
//   IDLE:  idx=0, out_valid=0. On accept -> RUN. If N_NEURONS==1 -> DRAIN instead.
//   RUN:   on the accept at idx==N_NEURONS-1 -> DRAIN.
//   DRAIN: last result pending; input still accepted only via the same-cycle rule as the next layer's idx 0.
//          On the out_last handshake: layer_done=1 for one cycle, then IDLE, or RUN if a new sum was accepted in that cycle.
// Thresholds:
// - cfg_we honoured only when busy==0: thr[cfg_addr] <= cfg_thr, effective for the next accept.
// - cfg_we while busy is ignored. cfg_addr >= N_NEURONS is ignored.
// - A cfg write in the same cycle as an IDLE accept is ignored, because the accept uses the old table.
// - rst at any time (mid-layer, mid-handshake) clears everything immediately, including the thresholds. The next sum after release is index 0.
// TESTING
// T1 reset: assert rst mid-clock -> out_valid=0, in_ready=1, busy=0, layer_done=0 asynchronously. Read-back via stream: sum 1 -> 1111 (thr 0).
// T2 layer: thr={3,5,7,9} for idx0..3, sums 4,5,8,9, out_ready=1 -> out_data 1111,0000,1111,0000; out_idx 0..3; out_last only on idx3; layer_done one cycle after idx3 handshake.
// T3 backpressure: hold out_ready=0 after idx1 result -> in_ready=0, out_data/out_idx stable for 5 cycles. Release -> stream resumes at idx2, no loss or duplication.
// T4 busy config: write thr[0]=15 while busy -> ignored. After layer_done, sum 10 at idx0 -> 1111 (old thr 3). After the write in IDLE, sum 10 -> 0000.
// T5 mid-layer reset: rst after idx2 accept -> outputs cleared. The next sum is tagged out_idx=0 against thr 0.
// T6 boundaries: thr=15/sum=15 -> 0000; thr=14/sum=15 -> 1111; thr=0/sum=0 -> 0000. Back-to-back layers: idx wraps 3->0 with no bubble.

Source files
------------

// File: rtl/activation_sequencer.sv
// activation_sequencer
//   Shares one step-activation unit across every neuron of a layer. Neuron
//   sums arrive in index order on a valid/ready stream. Each sum is compared
//   (unsigned, strict >) against a per-neuron threshold held in a small
//   register file. The all-ones or all-zeros activation goes out on a
//   valid/ready stream, together with its neuron index and a last flag.
//
// Ports
//   clk, rst           single rising-edge clock, asynchronous active-high reset
//   cfg_we/addr/thr    threshold write port (only honoured while idle)
//   in_valid/ready     input handshake, in_data = unsigned neuron sum
//   out_valid/ready    output handshake
//   out_data           activation, all ones or all zeros
//   out_idx            neuron index of out_data
//   out_last           result belongs to neuron N_NEURONS-1
//   busy               a layer is in progress
//   layer_done         one-cycle pulse after the last result is taken

`timescale 1ns/1ps

module activation_sequencer #(
  parameter int N_NEURONS = 4,
  parameter int W         = 4,
  parameter int IDX_W     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [W-1:0]     cfg_thr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             layer_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        out_valid_q, out_valid_d;
  logic [W-1:0]                out_data_q, out_data_d;
  logic [IDX_W-1:0]            out_idx_q, out_idx_d;
  logic                        out_last_q, out_last_d;
  logic                        layer_done_q, layer_done_d;
  logic [N_NEURONS-1:0][W-1:0] thr_q, thr_d;

  logic accept;
  logic out_hs;
  logic last_accept;
  logic cfg_ok;

  // A single output register with no skid buffer: input can only be taken
  // when that register is empty or is being emptied in this same cycle.
  assign in_ready    = !out_valid_q || out_ready;
  assign accept      = in_valid && in_ready;
  assign out_hs      = out_valid_q && out_ready;
  assign last_accept = accept && (idx_q == LAST_IDX);

  // The table is frozen during a layer. An accept while idle also blocks the
  // write, so the first neuron of the layer always sees the old table.
  assign cfg_ok = cfg_we && (state_q == IDLE) && !accept;

  // Threshold register file, one write decoder per entry. Addresses with no
  // matching entry select nothing and are dropped.
  genvar gi;
  generate
    for (gi = 0; gi < N_NEURONS; gi++) begin : g_thr
      assign thr_d[gi] = (cfg_ok && (int'(cfg_addr) == gi)) ? cfg_thr : thr_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thr_q <= '0;
    end else begin
      thr_q <= thr_d;
    end
  end

  // Datapath: index counter, output register and layer_done pulse.
  always_comb begin
    idx_d        = idx_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_idx_d    = out_idx_q;
    out_last_d   = out_last_q;
    layer_done_d = (state_q == DRAIN) && out_hs && out_last_q;
    if (accept) begin
      out_data_d  = (in_data > thr_q[idx_q]) ? '1 : '0;
      out_idx_d   = idx_q;
      out_last_d  = (idx_q == LAST_IDX);
      out_valid_d = 1'b1;
      idx_d       = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
      out_last_q   <= 1'b0;
      layer_done_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_idx_q    <= out_idx_d;
      out_last_q   <= out_last_d;
      layer_done_q <= layer_done_d;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. An accept in the same cycle as the last-result handshake
  // is the first neuron of the next layer, so DRAIN goes straight back to RUN
  // (or stays in DRAIN when a layer has only one neuron).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = last_accept ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (last_accept) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_hs && out_last_q) begin
          if (accept) begin
            state_d = last_accept ? DRAIN : RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q != IDLE);
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_idx    = out_idx_q;
  assign out_last   = out_last_q;
  assign layer_done = layer_done_q;

endmodule
